sdrc_req_acpt: RTL and testbench

Bank-side acceptor for the SDRAM request-generator interface. It takes page-chopped chunks (`r2b_*`), returns `b2r_ack` per chunk and `b2r_arb_ok` for new-request admission, and buffers chunks in a small FIFO. The bank FSMs drain that FIFO through a valid/ready port. It sits between `sdrc_req_gen` and the bank control logic inside the SDRAM controller core.

---
 rtl/sdrc_req_acpt_pkg.sv | 37 +++
 rtl/sdrc_sync_fifo.sv | 61 ++++++
 rtl/sdrc_req_acpt.sv | 140 ++++++++++++++
 tb/tb_sdrc_req_acpt.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_req_acpt_pkg.sv
// Shared types and constants for the bank-side request acceptor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Holds the request ID width, the packed chunk header layout, the entry-width
// helper and the protocol-checker state encoding.
package sdrc_req_acpt_pkg;

    localparam int SDR_REQ_ID_W = 4;

    // acpt_err bit positions: {caddr, id, framing}
    localparam int ERR_FRAMING = 0;
    localparam int ERR_ID      = 1;
    localparam int ERR_CADDR   = 2;

    // Everything except the length, which depends on APP_RW.
    typedef struct packed {
        logic [SDR_REQ_ID_W-1:0] id;
        logic                    start;
        logic                    last;
        logic                    wrap;
        logic                    write;
        logic [1:0]              ba;
        logic [11:0]             raddr;
        logic [11:0]             caddr;
    } acpt_hdr_t;

    typedef enum logic {
        CHK_IDLE  = 1'b0,
        CHK_BURST = 1'b1
    } chk_state_t;

    // Stored entry width: ID + start + last + wrap + write + ba + raddr + caddr + len.
    function automatic int acpt_entry_w(input int app_rw);
        return SDR_REQ_ID_W + 1 + 1 + 1 + 1 + 2 + 12 + 12 + app_rw;
    endfunction

endpackage

// File: rtl/sdrc_sync_fifo.sv
// Generic synchronous FIFO with full/empty/count.
// Latency: a push is visible at rdata one cycle later when the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty; full is judged
// on the pre-edge count, so a same-cycle pop never makes room for a push.
// Ports: clk/reset_n (sync, active-low), push/wdata, pop/rdata, full, empty, count.
module sdrc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdrc_req_acpt.sv
// Bank-side acceptor: acks page-chopped chunks from the request generator and queues them for the bank FSMs.
// Latency: b2r_ack is combinational; a chunk acked into an empty queue appears on bq_* the next cycle.
// Backpressure: ack withheld while the queue is full (pre-edge count); b2r_arb_ok drops when fewer than ARB_FREE entries are free.
// Ports: clk/reset_n (sync, active-low); r2b_* chunk in with b2r_ack/b2r_arb_ok;
// bq_* head out with bq_valid/bq_ready; bq_count occupancy; acpt_err sticky {caddr,id,framing}.
// Optional: SDRC_REQ_ACPT_CHK_EN compiles in the protocol checker; otherwise acpt_err is 0.
module sdrc_req_acpt
    import sdrc_req_acpt_pkg::*;
#(
    parameter int APP_RW   = 9,
    parameter int DEPTH    = 4,
    parameter int ARB_FREE = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    r2b_req,
    input  logic [SDR_REQ_ID_W-1:0] r2b_req_id,
    input  logic                    r2b_start,
    input  logic                    r2b_last,
    input  logic                    r2b_wrap,
    input  logic                    r2b_write,
    input  logic [1:0]              r2b_ba,
    input  logic [11:0]             r2b_raddr,
    input  logic [11:0]             r2b_caddr,
    input  logic [APP_RW-1:0]       r2b_len,
    output logic                    b2r_ack,
    output logic                    b2r_arb_ok,
    output logic                    bq_valid,
    input  logic                    bq_ready,
    output logic [SDR_REQ_ID_W-1:0] bq_id,
    output logic                    bq_start,
    output logic                    bq_last,
    output logic                    bq_wrap,
    output logic                    bq_write,
    output logic [1:0]              bq_ba,
    output logic [11:0]             bq_raddr,
    output logic [11:0]             bq_caddr,
    output logic [APP_RW-1:0]       bq_len,
    output logic [$clog2(DEPTH):0]  bq_count,
    output logic [2:0]              acpt_err
);

    localparam int EW = acpt_entry_w(APP_RW);

    acpt_hdr_t       wr_hdr;
    acpt_hdr_t       rd_hdr;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   rd_entry;
    logic            full;
    logic            empty;

    assign wr_hdr = '{id: r2b_req_id, start: r2b_start, last: r2b_last, wrap: r2b_wrap,
                      write: r2b_write, ba: r2b_ba, raddr: r2b_raddr, caddr: r2b_caddr};
    assign wr_entry = {wr_hdr, r2b_len};

    // Combinational so the generator can advance its address in the ack cycle.
    assign b2r_ack  = r2b_req & ~full;
    assign bq_valid = ~empty;

    sdrc_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (b2r_ack),
        .wdata   (wr_entry),
        .pop     (bq_ready),
        .rdata   (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (bq_count)
    );

    assign {rd_hdr, bq_len} = rd_entry;
    assign bq_id    = rd_hdr.id;
    assign bq_start = rd_hdr.start;
    assign bq_last  = rd_hdr.last;
    assign bq_wrap  = rd_hdr.wrap;
    assign bq_write = rd_hdr.write;
    assign bq_ba    = rd_hdr.ba;
    assign bq_raddr = rd_hdr.raddr;
    assign bq_caddr = rd_hdr.caddr;

    // Admission uses the registered count, so it lags a push/pop by one cycle.
    assign b2r_arb_ok = (DEPTH - int'(bq_count)) >= ARB_FREE;

`ifdef SDRC_REQ_ACPT_CHK_EN
    chk_state_t              chk_state;
    chk_state_t              chk_state_nxt;
    logic [SDR_REQ_ID_W-1:0] chk_id;
    logic [SDR_REQ_ID_W-1:0] chk_id_nxt;
    logic [2:0]              err_q;
    logic [2:0]              err_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chk_state <= CHK_IDLE;
            chk_id    <= '0;
            err_q     <= '0;
        end else begin
            chk_state <= chk_state_nxt;
            chk_id    <= chk_id_nxt;
            err_q     <= err_nxt;
        end
    end

    // Only accepted chunks are judged; errors accumulate and never clear.
    always_comb begin
        chk_state_nxt = chk_state;
        chk_id_nxt    = chk_id;
        err_nxt       = err_q;
        if (b2r_ack) begin
            case (chk_state)
                CHK_IDLE: begin
                    if (!r2b_start) begin
                        err_nxt[ERR_FRAMING] = 1'b1;
                    end else if (!r2b_last) begin
                        chk_id_nxt    = r2b_req_id;
                        chk_state_nxt = CHK_BURST;
                    end
                end
                CHK_BURST: begin
                    if (r2b_start || r2b_wrap)  err_nxt[ERR_FRAMING] = 1'b1;
                    if (r2b_req_id != chk_id)   err_nxt[ERR_ID]      = 1'b1;
                    // Continuation chunks always begin at the start of a page.
                    if (r2b_caddr != '0)        err_nxt[ERR_CADDR]   = 1'b1;
                    if (r2b_last)               chk_state_nxt        = CHK_IDLE;
                end
                default: chk_state_nxt = CHK_IDLE;
            endcase
        end
    end

    assign acpt_err = err_q;
`else
    assign acpt_err = 3'b000;
`endif

endmodule

// File: tb/tb_sdrc_req_acpt.sv
// Testbench for sdrc_req_acpt: directed test-plan steps plus a randomized phase,
// compared every cycle against a queue-based reference model.
module tb_sdrc_req_acpt;
    import sdrc_req_acpt_pkg::*;

    localparam int APP_RW   = 9;
    localparam int DEPTH    = 4;
    localparam int ARB_FREE = 2;

    typedef struct packed {
        logic [SDR_REQ_ID_W-1:0] id;
        logic                    start;
        logic                    last;
        logic                    wrap;
        logic                    write;
        logic [1:0]              ba;
        logic [11:0]             raddr;
        logic [11:0]             caddr;
        logic [APP_RW-1:0]       len;
    } chunk_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req = 1'b0;
    logic ready = 1'b0;
    chunk_t cur = '0;
    chunk_t head_obs;

    logic                    b2r_ack, b2r_arb_ok, bq_valid;
    logic [SDR_REQ_ID_W-1:0] bq_id;
    logic                    bq_start, bq_last, bq_wrap, bq_write;
    logic [1:0]              bq_ba;
    logic [11:0]             bq_raddr, bq_caddr;
    logic [APP_RW-1:0]       bq_len;
    logic [$clog2(DEPTH):0]  bq_count;
    logic [2:0]              acpt_err;

    always #5 clk = ~clk;

    sdrc_req_acpt #(.APP_RW(APP_RW), .DEPTH(DEPTH), .ARB_FREE(ARB_FREE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .r2b_req    (req),
        .r2b_req_id (cur.id),
        .r2b_start  (cur.start),
        .r2b_last   (cur.last),
        .r2b_wrap   (cur.wrap),
        .r2b_write  (cur.write),
        .r2b_ba     (cur.ba),
        .r2b_raddr  (cur.raddr),
        .r2b_caddr  (cur.caddr),
        .r2b_len    (cur.len),
        .b2r_ack    (b2r_ack),
        .b2r_arb_ok (b2r_arb_ok),
        .bq_valid   (bq_valid),
        .bq_ready   (ready),
        .bq_id      (bq_id),
        .bq_start   (bq_start),
        .bq_last    (bq_last),
        .bq_wrap    (bq_wrap),
        .bq_write   (bq_write),
        .bq_ba      (bq_ba),
        .bq_raddr   (bq_raddr),
        .bq_caddr   (bq_caddr),
        .bq_len     (bq_len),
        .bq_count   (bq_count),
        .acpt_err   (acpt_err)
    );

    assign head_obs = '{id: bq_id, start: bq_start, last: bq_last, wrap: bq_wrap, write: bq_write,
                        ba: bq_ba, raddr: bq_raddr, caddr: bq_caddr, len: bq_len};

    // Reference model: ordered queue of accepted chunks plus expected error flags.
    chunk_t     mq[$];
    logic [2:0] m_err = 3'b000;
    bit         m_burst = 1'b0;
    logic [SDR_REQ_ID_W-1:0] m_id = '0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit exp_ack;
        bit exp_pop;
        @(negedge clk);
        exp_ack = req && (mq.size() < DEPTH);
        exp_pop = ready && (mq.size() != 0);
        check("ack", b2r_ack, exp_ack);
        check("valid", bq_valid, mq.size() != 0);
        if (mq.size() != 0) check("head", head_obs, mq[0]);
        check("count", bq_count, mq.size());
        check("arb_ok", b2r_arb_ok, (DEPTH - mq.size()) >= ARB_FREE);
        check("err", acpt_err, m_err);
        @(posedge clk);
        if (exp_pop) void'(mq.pop_front());
        if (exp_ack) begin
            mq.push_back(cur);
`ifdef SDRC_REQ_ACPT_CHK_EN
            if (!m_burst) begin
                if (!cur.start) m_err[0] = 1'b1;
                else if (!cur.last) begin
                    m_burst = 1'b1;
                    m_id = cur.id;
                end
            end else begin
                if (cur.start || cur.wrap) m_err[0] = 1'b1;
                if (cur.id != m_id)        m_err[1] = 1'b1;
                if (cur.caddr != 12'h000)  m_err[2] = 1'b1;
                if (cur.last)              m_burst = 1'b0;
            end
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_err = 3'b000;
        m_burst = 1'b0;
    endtask

    function automatic chunk_t rand_chunk(input bit clean);
        chunk_t c;
        c.id    = SDR_REQ_ID_W'($urandom());
        c.start = clean ? 1'b1 : 1'($urandom());
        c.last  = clean ? 1'b1 : 1'($urandom());
        c.wrap  = 1'($urandom());
        c.write = 1'($urandom());
        c.ba    = 2'($urandom());
        c.raddr = 12'($urandom());
        c.caddr = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom());
        c.len   = APP_RW'($urandom());
        return c;
    endfunction

    function automatic chunk_t mk(input int id, input bit s, input bit l, input bit w,
                                  input int ba, input int ra, input int ca, input int len);
        chunk_t c;
        c.id = SDR_REQ_ID_W'(id); c.start = s; c.last = l; c.wrap = 1'b0; c.write = w;
        c.ba = 2'(ba); c.raddr = 12'(ra); c.caddr = 12'(ca); c.len = APP_RW'(len);
        return c;
    endfunction

    initial begin
        logic [2:0] exp_chk_err;

        // Reset state
        do_reset();
        check("rst_valid", bq_valid, 1'b0);
        check("rst_count", bq_count, 0);
        check("rst_arb_ok", b2r_arb_ok, 1'b1);
        check("rst_ack", b2r_ack, 1'b0);
        check("rst_err", acpt_err, 3'b000);

        // Single chunk: same-cycle ack, visible next cycle
        cur = mk(3, 1, 1, 0, 1, 'h12, 'h20, 8);
        req = 1'b1;
        cycle();
        req = 1'b0;
        check("one_caddr", bq_caddr, 12'h020);
        check("one_count", bq_count, 1);
        cycle();
        ready = 1'b1;
        cycle();
        ready = 1'b0;

        // Split request queued in order, then a third chunk drops arb_ok
        cur = mk(7, 1, 0, 1, 2, 'h55, 'hF0, 16);
        req = 1'b1; cycle(); req = 1'b0; cycle();
        cur = mk(7, 0, 1, 1, 2, 'h55, 'h00, 16);
        req = 1'b1; cycle(); req = 1'b0; cycle();
        check("split_arb_ok2", b2r_arb_ok, 1'b1);
        cur = mk(1, 1, 1, 0, 0, 'h01, 'h10, 4);
        req = 1'b1; cycle(); req = 1'b0;
        check("split_count3", bq_count, 3);
        check("split_arb_drop", b2r_arb_ok, 1'b0);
        check("split_err", acpt_err, 3'b000);

        // Fill to DEPTH, hold req while full, then one pop makes room next cycle
        cur = rand_chunk(1'b1);
        req = 1'b1; cycle();
        for (int i = 0; i < 3; i++) cycle();
        check("full_no_ack", b2r_ack, 1'b0);
        ready = 1'b1; cycle(); ready = 1'b0;
        cycle();
        req = 1'b0;
        check("full_refill", bq_count, DEPTH);

        // Drain to 2, then concurrent push and pop for 10 cycles
        ready = 1'b1;
        cycle(); cycle();
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = rand_chunk(1'b1);
            cycle();
        end
        req = 1'b0;
        check("steady_count", bq_count, 2);
        cycle(); cycle();
        ready = 1'b0;

        // Checker: repeated start inside a burst, then an ID change
        cur = mk(5, 1, 0, 0, 3, 'h77, 'h40, 16);
        req = 1'b1; cycle(); req = 1'b0; cycle();
        cur = mk(5, 1, 0, 0, 3, 'h77, 'h00, 16);
        req = 1'b1; cycle(); req = 1'b0; cycle();
        cur = mk(6, 0, 0, 0, 3, 'h77, 'h00, 16);
        req = 1'b1; cycle(); req = 1'b0;
        cycle(); cycle();
`ifdef SDRC_REQ_ACPT_CHK_EN
        exp_chk_err = 3'b011;
`else
        exp_chk_err = 3'b000;
`endif
        check("chk_err", acpt_err, exp_chk_err);
        cycle();
        check("chk_err_sticky", acpt_err, exp_chk_err);

        // Reset with three entries queued discards them
        check("pre_rst_count", bq_count, 3);
        do_reset();
        check("mid_rst_valid", bq_valid, 1'b0);
        check("mid_rst_count", bq_count, 0);
        check("mid_rst_arb_ok", b2r_arb_ok, 1'b1);
        check("mid_rst_err", acpt_err, 3'b000);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            cur   = rand_chunk($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
